led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Time-multiplexed scan controller for the iceFUN 8×4 LED matrix: it owns the active-low row drivers (`led[7:0]`) and column selects (`lcol[3:0]`), walks the four columns with blanking between them, and applies global PWM brightness. Client logic writes column patterns into a back buffer and requests a swap; the swap lands atomically at a frame boundary, so the display never tears. It sits directly between application logic and the board pins, replacing static LED assignments.

## Interface
Parameters:
- `DWELL`, 3000: cycles per column (12 MHz → 4 kHz column rate, 1 kHz frame rate); ≥ `BLANK`+16.
- `BLANK`, 16: dead cycles at the start of each column with all rows and columns off (anti-ghosting); ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock, 12 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe into back buffer.
- `wr_col`  in  2  back-buffer column index.
- `wr_data`  in  8  column pattern; bit i = row i, 1 = lit.
- `swap_req`  in  1  level; hold high until `swap_ack`.
- `swap_ack`  out  1  one-cycle pulse; back buffer now displayed.
- `brightness`  in  4  0 = dark, n = n/16 duty within drive window.
- `frame_start`  out  1  one-cycle pulse at column 0, slot 0.
- `led`  out  8  row drivers, active low.
- `lcol`  out  4  column selects, active low; column c drives `lcol[c]` low.

## Operation
- Counters: `col` 0..3, `slot` 0..DWELL-1. `slot` wraps at DWELL-1 and advances `col`; `col` wraps 3→0.
- States: BLANK (slot < BLANK) → DRIVE (BLANK ≤ slot ≤ DWELL-1) → BLANK of next column. No other states.
- BLANK: `lcol`=4'hF, `led`=8'hFF.
- DRIVE: `lcol`=~(1<<col). 4-bit `pwm_phase` clears on DRIVE entry and increments every DRIVE cycle (wraps 15→0). Rows are lit when `pwm_phase` < `bri_q`: `led`=~front[col]; otherwise `led`=8'hFF with the column still selected.
- `bri_q` samples `brightness` on the last BLANK cycle of each column. It is constant within a drive window.
- Write: when `wr_en`=1, back[wr_col] <= wr_data. No effect on the display until a swap.
- Swap: on the frame-end cycle (col=3, slot=DWELL-1) with `swap_req`=1, front[0..3] <= back[0..3].
  - The copy uses back contents from before any same-cycle write. That write is kept in back only.
  - `swap_ack` pulses on the following cycle.
  - If `swap_req` drops before frame end, no swap occurs.
  - If `swap_req` stays high after ack, a swap occurs again every frame.
- Reset (asserted at any time, including mid-column):
  - `led`=8'hFF, `lcol`=4'hF, `swap_ack`=0, `frame_start`=0.
  - front and back buffers cleared to 0; `col`=0, `slot`=0, `bri_q`=0, state BLANK.
  - After release, scanning restarts at column 0, slot 0.

## Timing
- All outputs are registered. `led`/`lcol` reflect the (col, slot) state of the previous cycle (1-cycle latency).
- `frame_start` is high in the cycle where the registered outputs begin column 0 BLANK. The first pulse is the first cycle after reset release.
- Frame = 4·DWELL cycles. Drive window = DWELL-BLANK cycles per column.
- Column change always passes through ≥ BLANK cycles of `lcol`=4'hF. Two columns are never low simultaneously, including across reset.
- `swap_ack` coincides with `frame_start`. The new front contents appear on column 0's first DRIVE cycle.

## Structure
- Package `led_matrix_pkg`: `NUM_COLS`=4, `NUM_ROWS`=8, state enum {BLANK, DRIVE}, column/row typedefs.
- Sub-module `led_frame_buffer`: back/front 4×8 registers, write port, frame-end swap, `swap_ack`.
- Top-level `led_matrix_scanner` contains counters, FSM, PWM gate and output registers.

## Test plan
Bench parameters: DWELL=40, BLANK=4.
- Reset release, no writes → `led`=8'hFF every cycle. `lcol` cycles 1110,1101,1011,0111, each low for 36 cycles, separated by 4 cycles of 1111. `frame_start` period = 160.
- Write back[2]=8'hA5, `brightness`=15, hold `swap_req` → exactly one `swap_ack`, aligned with `frame_start`. During `lcol`=1011, `led`=8'h5A for 15 of every 16 DRIVE cycles and 8'hFF on phase 15. Other columns show 8'hFF.
- `brightness`=4 with front[0]=8'hFF → in column 0 DRIVE, `led`=8'h00 for phases 0–3 and 8'hFF for phases 4–15. Changing `brightness` mid-window has no effect until the next column.
- `wr_en` to back[1] on the frame-end cycle with `swap_req`=1 → the displayed column 1 shows the old back value. The new value appears only after the next swap.
- `swap_req` pulsed high then dropped before frame end → no `swap_ack`, display unchanged.
- Assert `reset` mid-DRIVE of column 2 → `lcol`=4'hF and `led`=8'hFF in the same cycle (async). Buffers are 0. The first `frame_start` comes 1 cycle after release.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the iceFUN 8x4 LED matrix scanner.
//   NUM_COLS / NUM_ROWS : matrix geometry
//   col_t / row_t       : column index and row pattern types
//   scan_state_e        : per-column scan phase (blanking or driving)
package led_matrix_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 8;

    typedef logic [1:0]          col_t;
    typedef logic [NUM_ROWS-1:0] row_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered column store for the LED matrix.
//   clock, reset       : system clock, async active-high reset (clears both buffers)
//   wr_en/wr_col/wr_data : client write into the back buffer
//   frame_end          : high on the last (col 3, last slot) scan cycle
//   swap_req           : level request; copies back -> front at frame_end
//   rd_col / rd_data   : combinational read of the front buffer for the scanner
//   swap_ack           : one-cycle pulse, aligned with the scanner's frame_start
module led_frame_buffer
    import led_matrix_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       frame_end,
    input  logic       swap_req,
    input  logic [1:0] rd_col,
    output logic [7:0] rd_data,
    output logic       swap_ack
);

    row_t back_q  [NUM_COLS];
    row_t front_q [NUM_COLS];
    logic swap_go;
    logic swap_done_q;
    logic swap_ack_q;

    assign swap_go = frame_end & swap_req;

    // NOTE: the buffers are small flop arrays, so they take the async reset
    // like everything else; a RAM-style array without reset would show stale
    // patterns after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
            swap_done_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments mean the copy below sees back_q as
            // it was before this cycle's write, so a same-cycle write stays in
            // the back buffer only.
            if (swap_go) begin
                for (int i = 0; i < NUM_COLS; i++) begin
                    front_q[i] <= back_q[i];
                end
            end
            if (wr_en) begin
                back_q[wr_col] <= wr_data;
            end
            // Two stages: the scanner's registered outputs show column 0 slot 0
            // two cycles after frame_end, and the ack is aligned with that.
            swap_done_q <= swap_go;
            swap_ack_q  <= swap_done_q;
        end
    end

    assign rd_data  = front_q[rd_col];
    assign swap_ack = swap_ack_q;

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed scan controller for the iceFUN 8x4 LED matrix.
//   clock, reset       : 12 MHz clock, async active-high reset
//   wr_en/wr_col/wr_data : back-buffer writes (bit i = row i, 1 = lit)
//   swap_req/swap_ack  : frame-synchronous back -> front swap handshake
//   brightness         : n/16 PWM duty inside each column's drive window
//   frame_start        : pulse when outputs begin column 0 blanking
//   led / lcol         : active-low row drivers and column selects (registered)
// Each column spends DWELL cycles: BLANK cycles all-off, then the drive window.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int DWELL = 3000,
    parameter int BLANK = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    input  logic [3:0] brightness,
    output logic       frame_start,
    output logic [7:0] led,
    output logic [3:0] lcol
);

    localparam int SLOT_W = $clog2(DWELL);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    col_t              col_q, col_d;
    scan_state_e       state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    logic [3:0]        bri_q, bri_d;
    logic [7:0]        led_q, led_d;
    logic [3:0]        lcol_q, lcol_d;
    logic              frame_start_q, frame_start_d;

    logic last_slot;
    logic last_blank;
    logic frame_end;
    row_t front_col;

    assign last_slot  = (slot_q == SLOT_LAST);
    assign last_blank = (slot_q == BLANK_LAST);
    assign frame_end  = last_slot && (col_q == col_t'(NUM_COLS - 1));

    led_frame_buffer u_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .frame_end(frame_end),
        .swap_req (swap_req),
        .rd_col   (col_q),
        .rd_data  (front_col),
        .swap_ack (swap_ack)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        slot_d        = last_slot ? '0 : slot_q + 1'b1;
        col_d         = last_slot ? col_q + 1'b1 : col_q;
        bri_d         = last_blank ? brightness : bri_q;
        frame_start_d = (col_q == '0) && (slot_q == '0);

        state_d = state_q;
        if (last_slot) begin
            state_d = ST_BLANK;
        end else if (last_blank) begin
            state_d = ST_DRIVE;
        end

        // Holding the phase at zero while blanking gives a cleared phase on
        // the first drive cycle.
        phase_d = (state_q == ST_DRIVE) ? phase_q + 4'd1 : 4'd0;

        lcol_d = 4'hF;
        led_d  = 8'hFF;
        if (state_q == ST_DRIVE) begin
            lcol_d = ~(4'b0001 << col_q);
            if (phase_q < bri_q) begin
                led_d = ~front_col;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q        <= '0;
            col_q         <= '0;
            state_q       <= ST_BLANK;
            phase_q       <= '0;
            bri_q         <= '0;
            led_q         <= 8'hFF;
            lcol_q        <= 4'hF;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            col_q         <= col_d;
            state_q       <= state_d;
            phase_q       <= phase_d;
            bri_q         <= bri_d;
            led_q         <= led_d;
            lcol_q        <= lcol_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign led         = led_q;
    assign lcol        = lcol_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (DWELL=40, BLANK=4).
module tb_led_matrix_scanner;

    localparam int DWELL = 40;
    localparam int BLANK = 4;
    localparam int NCOL  = 4;
    localparam int FRAME = NCOL * DWELL;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       wr_en      = 1'b0;
    logic [1:0] wr_col     = 2'd0;
    logic [7:0] wr_data    = 8'd0;
    logic       swap_req   = 1'b0;
    logic [3:0] brightness = 4'd0;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] led;
    logic [3:0] lcol;

    led_matrix_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .brightness (brightness),
        .frame_start(frame_start),
        .led        (led),
        .lcol       (lcol)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_s counts scan cycles since reset release; column,
    // slot and PWM phase follow from it arithmetically.
    int         m_s;
    logic [7:0] m_front [NCOL];
    logic [7:0] m_back  [NCOL];
    logic [3:0] m_bri;
    logic       m_swap_prev;

    logic [7:0] obs_led;
    logic [3:0] obs_lcol;
    logic       obs_ack;
    logic       obs_fs;
    int         ack_count = 0;
    int         last_fs_s;
    int         fs_period;

    typedef struct {
        int         col;
        logic [7:0] pattern;
        logic [3:0] bri;
        int         lit;
        logic [7:0] led_on;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 0;
        for (int i = 0; i < NCOL; i++) begin
            m_front[i] = 8'h00;
            m_back[i]  = 8'h00;
        end
        m_bri       = 4'd0;
        m_swap_prev = 1'b0;
        last_fs_s   = -1;
        fs_period   = 0;
    endtask

    // One clock: predict outputs for the current model cycle, advance the
    // model with the inputs presented this cycle, clock the DUT, compare.
    task automatic step();
        int         col;
        int         slot;
        int         phase;
        logic [7:0] e_led;
        logic [3:0] e_lcol;
        logic       e_fs;
        logic       e_ack;
        col  = (m_s / DWELL) % NCOL;
        slot = m_s % DWELL;
        if (slot < BLANK) begin
            e_lcol = 4'hF;
            e_led  = 8'hFF;
        end else begin
            e_lcol = ~(4'b0001 << col);
            phase  = (slot - BLANK) % 16;
            e_led  = (phase < int'(m_bri)) ? ~m_front[col] : 8'hFF;
        end
        e_fs  = (m_s % FRAME) == 0;
        e_ack = m_swap_prev;

        if (slot == BLANK - 1) m_bri = brightness;
        m_swap_prev = ((m_s % FRAME) == FRAME - 1) && swap_req;
        if (m_swap_prev) begin
            for (int i = 0; i < NCOL; i++) m_front[i] = m_back[i];
        end
        if (wr_en) m_back[wr_col] = wr_data;

        @(posedge clock);
        #1;
        obs_led  = led;
        obs_lcol = lcol;
        obs_ack  = swap_ack;
        obs_fs   = frame_start;
        if (obs_ack) ack_count++;
        if (obs_fs) begin
            if (last_fs_s >= 0) fs_period = m_s - last_fs_s;
            last_fs_s = m_s;
        end
        check($sformatf("scan@%0d {fs,ack,lcol,led}", m_s),
              32'({obs_fs, obs_ack, obs_lcol, obs_led}),
              32'({e_fs, e_ack, e_lcol, e_led}));
        m_s++;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < FRAME && (m_s % FRAME) != target; k++) step();
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * FRAME + 4 && !seen; k++) begin
            step();
            if (obs_ack) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("ack_with_frame_start", 32'(obs_fs), 32'd1);
    endtask

    // Observe one full drive window of column col; count lit cycles.
    task automatic measure(input int col, input int change_at, input logic [3:0] new_bri,
                           output int lit, output logic [7:0] val);
        logic [3:0] sel;
        sel = ~(4'b0001 << col);
        lit = 0;
        val = 8'hFF;
        run_to(col * DWELL + BLANK);
        for (int k = 0; k < DWELL - BLANK; k++) begin
            if (k == change_at) brightness = new_bri;
            step();
            if (obs_lcol == sel && obs_led != 8'hFF) begin
                lit++;
                val = obs_led;
            end
        end
    endtask

    task automatic write_back(input int col, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_col  = 2'(col);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int         lit;
        logic [7:0] val;
        int         a0;

        // Lit count over a 36-cycle window = 2*b + min(b,4).
        vecs[0] = '{2, 8'hA5, 4'd15, 34, 8'h5A};
        vecs[1] = '{0, 8'hFF, 4'd4,  12, 8'h00};
        vecs[2] = '{1, 8'h3C, 4'd0,  0,  8'hC3};
        vecs[3] = '{3, 8'h81, 4'd8,  20, 8'h7E};
        vecs[4] = '{1, 8'h01, 4'd1,  3,  8'hFE};

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_led", 32'(led), 32'hFF);
        check("reset_lcol", 32'(lcol), 32'hF);
        check("reset_fs_ack", 32'({frame_start, swap_ack}), 32'd0);
        reset = 1'b0;

        // Idle scanning: blank display, frame period, no acks.
        step();
        check("first_fs_after_release", 32'(obs_fs), 32'd1);
        for (int k = 0; k < 2 * FRAME; k++) step();
        check("idle_no_ack", 32'(ack_count), 32'd0);
        check("frame_period", 32'(fs_period), 32'(FRAME));

        // Table: write, swap, then observe the written column's drive window.
        for (int i = 0; i < 5; i++) begin
            a0 = ack_count;
            brightness = vecs[i].bri;
            write_back(vecs[i].col, vecs[i].pattern);
            swap_req = 1'b1;
            wait_ack();
            swap_req = 1'b0;
            measure(vecs[i].col, -1, 4'd0, lit, val);
            check($sformatf("vec%0d_lit", i), 32'(lit), 32'(vecs[i].lit));
            if (vecs[i].lit > 0) check($sformatf("vec%0d_led", i), 32'(val), 32'(vecs[i].led_on));
            for (int k = 0; k < FRAME; k++) step();
            check($sformatf("vec%0d_one_ack", i), 32'(ack_count - a0), 32'd1);
        end

        // Brightness change mid-window only takes effect next column visit.
        brightness = 4'd4;
        measure(0, 10, 4'd15, lit, val);
        check("mid_change_lit", 32'(lit), 32'd12);
        check("mid_change_led", 32'(val), 32'h00);
        measure(0, -1, 4'd0, lit, val);
        check("after_change_lit", 32'(lit), 32'd34);

        // Write on the frame-end cycle stays in the back buffer.
        write_back(1, 8'h0F);
        run_to(FRAME - 1);
        swap_req = 1'b1;
        write_back(1, 8'hF0);
        wait_ack();
        swap_req = 1'b0;
        measure(1, -1, 4'd0, lit, val);
        check("frame_end_write_old", 32'(val), 32'hF0);
        swap_req = 1'b1;
        wait_ack();
        swap_req = 1'b0;
        measure(1, -1, 4'd0, lit, val);
        check("frame_end_write_new", 32'(val), 32'h0F);

        // swap_req withdrawn before frame end: no swap.
        write_back(1, 8'h55);
        a0 = ack_count;
        run_to(20);
        swap_req = 1'b1;
        repeat (5) step();
        swap_req = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) step();
        check("dropped_req_no_ack", 32'(ack_count - a0), 32'd0);
        measure(1, -1, 4'd0, lit, val);
        check("dropped_req_display", 32'(val), 32'h0F);

        // Randomized traffic against the model.
        for (int k = 0; k < 3 * FRAME; k++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_col  = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 63) == 0) swap_req = ~swap_req;
            step();
        end
        wr_en    = 1'b0;
        swap_req = 1'b0;
        write_back(2, 8'hC3);
        swap_req = 1'b1;
        wait_ack();
        swap_req = 1'b0;

        // Asynchronous reset in the middle of column 2's drive window.
        brightness = 4'd15;
        run_to(2 * DWELL + 20);
        reset = 1'b1;
        #1;
        check("async_lcol", 32'(lcol), 32'hF);
        check("async_led", 32'(led), 32'hFF);
        check("async_fs_ack", 32'({frame_start, swap_ack}), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("held_reset_lcol", 32'(lcol), 32'hF);
        reset = 1'b0;
        model_reset();
        step();
        check("fs_after_mid_reset", 32'(obs_fs), 32'd1);
        measure(2, -1, 4'd0, lit, val);
        check("front_cleared", 32'(lit), 32'd0);
        swap_req = 1'b1;
        wait_ack();
        swap_req = 1'b0;
        measure(2, -1, 4'd0, lit, val);
        check("back_cleared", 32'(lit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
